// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan pattern sequencer.
package scan_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    REPORT
  } state_t;

  localparam int FAIL_CNT_W = 8;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load / serial-shift register: shifts right, serial input enters at the MSB.
// Serves as the stimulus source during load and the response collector during unload.
module scan_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  // NOTE: pure datapath storage with no reset; every pattern fully overwrites it
  // (parallel load, then CHAIN_LEN unload shifts) before anything reads it.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {ser_in, q[W-1:1]};
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Scan test sequencer: loads a pattern LSB first, opens a capture window,
// unloads the response, compares it with the expected value and counts failures.
module scan_seq
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic [CHAIN_LEN-1:0]  pat_data,
  input  logic [CHAIN_LEN-1:0]  pat_expect,
  input  logic                  abort,
  input  logic                  clr_cnt,
  output logic                  scan_in_o,
  input  logic                  scan_out_i,
  output logic                  shift_en,
  output logic [CHAIN_LEN-1:0]  resp,
  output logic                  resp_valid,
  output logic                  fail,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam int MAX_LEN = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] LAST_CHAIN = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(CAPTURE_CYCLES - 1);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic                 ready_q;
  logic                 accept;
  logic                 last_unload;
  logic                 count_hit;
  logic [CHAIN_LEN-1:0] sh_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] resp_nx;

  // ready_q keeps pat_ready low until the first clock after reset release.
  assign pat_ready   = (state == IDLE) && ready_q;
  assign accept      = pat_valid && pat_ready;
  assign last_unload = (state == UNLOAD) && (cnt == LAST_CHAIN) && !abort;
  assign resp_nx     = {scan_out_i, sh_q[CHAIN_LEN-1:1]};
  assign count_hit   = (state == REPORT) && fail;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    shift_en   = 1'b1;
    scan_in_o  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = LOAD;
      end
      LOAD: begin
        scan_in_o = sh_q[0];
        if (abort)                   state_nx = IDLE;
        else if (cnt == LAST_CHAIN)  state_nx = CAPTURE;
      end
      CAPTURE: begin
        shift_en = 1'b0;
        if (abort)                   state_nx = IDLE;
        else if (cnt == LAST_CAP)    state_nx = UNLOAD;
      end
      UNLOAD: begin
        if (abort)                   state_nx = IDLE;
        else if (cnt == LAST_CHAIN)  state_nx = REPORT;
      end
      REPORT: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= 1'b1;
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state inside {LOAD, CAPTURE, UNLOAD}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) exp_q <= pat_expect;
  end

  // resp and fail change only on a completed unload, so they hold between reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp     <= '0;
      fail     <= 1'b0;
      fail_cnt <= '0;
    end else begin
      if (last_unload) begin
        resp <= resp_nx;
        fail <= (resp_nx != exp_q);
      end
      if (clr_cnt) begin
        fail_cnt <= count_hit ? FAIL_CNT_W'(1) : '0;
      end else if (count_hit && (fail_cnt != '1)) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

  scan_shreg #(.W(CHAIN_LEN)) u_shreg (
    .clk       (clk),
    .load      (accept),
    .load_data (pat_data),
    .shift     ((state == LOAD) || (state == UNLOAD)),
    .ser_in    (scan_out_i),
    .q         (sh_q)
  );

endmodule

// File: tb/tb_scan_seq.sv
// Directed bench for scan_seq: a 16-bit model chain loops scan_in_o back to
// scan_out_i with a no-op capture, so the unloaded response equals the pattern.
module tb_scan_seq;

  localparam int CL = 16;
  localparam int CC = 6;
  localparam int RV_LAT = CL + CC + CL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pat_valid = 1'b0;
  logic          abort = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [CL-1:0] pat_data = '0;
  logic [CL-1:0] pat_expect = '0;
  logic          pat_ready, scan_in_o, scan_out_i, shift_en, resp_valid, fail;
  logic [CL-1:0] resp;
  logic [7:0]    fail_cnt;
  logic [CL-1:0] chain = '0;

  int n_vec = 0;
  int n_bad = 0;
  int model_cnt = 0;

  typedef struct {
    logic [CL-1:0] data;
    logic [CL-1:0] expct;
    logic [CL-1:0] resp;
    logic          fail;
  } vec_t;

  vec_t vecs[6];

  scan_seq #(.CHAIN_LEN(CL), .CAPTURE_CYCLES(CC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .pat_expect (pat_expect),
    .abort      (abort),
    .clr_cnt    (clr_cnt),
    .scan_in_o  (scan_in_o),
    .scan_out_i (scan_out_i),
    .shift_en   (shift_en),
    .resp       (resp),
    .resp_valid (resp_valid),
    .fail       (fail),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // Model chain: head takes scan_in_o, tail drives scan_out_i; holds while capturing.
  always @(posedge clk) if (shift_en) chain <= {chain[CL-2:0], scan_in_o};
  assign scan_out_i = chain[CL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_report(input logic f, input logic clr);
    if (clr)                       model_cnt = f ? 1 : 0;
    else if (f && model_cnt < 255) model_cnt++;
  endtask

  // One full pattern; returns positioned at the IDLE cycle after REPORT.
  task automatic run_pattern(input logic [CL-1:0] d, input logic [CL-1:0] e,
                             input logic [CL-1:0] r, input logic f,
                             input logic clr, input bit verbose);
    int t, rv_at, low;
    bit sin_ok;
    t = 0;
    while (!pat_ready && t < 100) begin step(); t++; end
    if (!pat_ready) check("pat_ready wait", pat_ready, 1);
    pat_valid = 1'b1; pat_data = d; pat_expect = e;
    step();
    // Scramble the inputs: the DUT must use its registered copies.
    pat_valid = 1'b0; pat_data = ~d; pat_expect = ~e;
    rv_at = -1; low = 0; sin_ok = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k < CL && (scan_in_o !== d[k] || shift_en !== 1'b1)) sin_ok = 1'b0;
      if (!shift_en) low++;
      if (resp_valid) begin rv_at = k; break; end
      step();
    end
    if (verbose || rv_at < 0) check("resp_valid latency", rv_at, RV_LAT);
    if (rv_at < 0) return;
    if (verbose) begin
      check("load scan_in_o LSB first", sin_ok, 1);
      check("shift_en low cycles", low, CC);
      check("resp", resp, r);
      check("fail", fail, f);
    end
    clr_cnt = clr;
    step();
    clr_cnt = 1'b0;
    model_report(f, clr);
    if (verbose) begin
      check("resp_valid one cycle", resp_valid, 0);
      check("idle after report", pat_ready, 1);
      check("resp held", resp, r);
      check("fail_cnt", fail_cnt, model_cnt);
    end
  endtask

  initial begin
    int n_acc, n_rv, low;
    bit changed, rv_seen;
    int acc_t[3];
    int rv_t[2];
    logic [CL-1:0] rv_r[2];
    logic rv_f[2];

    vecs[0] = '{data: 16'hA5C3, expct: 16'hA5C3, resp: 16'hA5C3, fail: 1'b0};
    vecs[1] = '{data: 16'hA5C3, expct: 16'hA5C2, resp: 16'hA5C3, fail: 1'b1};
    vecs[2] = '{data: 16'h0000, expct: 16'h0000, resp: 16'h0000, fail: 1'b0};
    vecs[3] = '{data: 16'hFFFF, expct: 16'h7FFF, resp: 16'hFFFF, fail: 1'b1};
    vecs[4] = '{data: 16'h8001, expct: 16'h8001, resp: 16'h8001, fail: 1'b0};
    vecs[5] = '{data: 16'h1234, expct: 16'h4321, resp: 16'h1234, fail: 1'b1};
    acc_t = '{0, 0, 0};
    rv_t  = '{0, 0};
    rv_r  = '{16'h0, 16'h0};
    rv_f  = '{1'b0, 1'b0};

    // Reset values while rst_n is held low.
    #12;
    check("rst shift_en", shift_en, 1);
    check("rst pat_ready", pat_ready, 0);
    check("rst scan_in_o", scan_in_o, 0);
    check("rst resp", resp, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst fail", fail, 0);
    check("rst fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("pat_ready before first clock", pat_ready, 0);
    step();
    check("pat_ready after first clock", pat_ready, 1);

    foreach (vecs[i])
      run_pattern(vecs[i].data, vecs[i].expct, vecs[i].resp, vecs[i].fail, 1'b0, 1'b1);

    // Abort in CAPTURE cycle 2 with a failing expect: nothing must be reported.
    pat_valid = 1'b1; pat_data = 16'hA5C3; pat_expect = 16'h0000;
    step();
    pat_valid = 1'b0;
    repeat (CL + 2) step();
    check("capture before abort", shift_en, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort shift_en", shift_en, 1);
    check("abort to idle", pat_ready, 1);
    rv_seen = 1'b0;
    repeat (50) begin
      if (resp_valid) rv_seen = 1'b1;
      step();
    end
    check("abort no resp_valid", rv_seen, 0);
    check("abort fail_cnt kept", fail_cnt, model_cnt);

    // Saturation, then clear coinciding with a failing report, then a plain clear.
    for (int i = 0; i < 256; i++)
      run_pattern(16'h00FF, 16'h00FE, 16'h00FF, 1'b1, 1'b0, 1'b0);
    check("fail_cnt saturated", fail_cnt, 255);
    run_pattern(16'h3C3C, 16'h3C3D, 16'h3C3C, 1'b1, 1'b1, 1'b1);
    check("clr with failing report", fail_cnt, 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    model_cnt = 0;
    check("clr in idle", fail_cnt, 0);

    // Async reset in UNLOAD cycle 5, after a failing pattern left state behind.
    run_pattern(16'h5A5A, 16'h5A5B, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    pat_valid = 1'b1; pat_data = 16'hC0DE; pat_expect = 16'hC0DE;
    step();
    pat_valid = 1'b0;
    repeat (CL + CC + 5) step();
    check("unload before reset", {shift_en, pat_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst shift_en", shift_en, 1);
    check("mid rst pat_ready", pat_ready, 0);
    check("mid rst scan_in_o", scan_in_o, 0);
    check("mid rst resp", resp, 0);
    check("mid rst resp_valid", resp_valid, 0);
    check("mid rst fail", fail, 0);
    check("mid rst fail_cnt", fail_cnt, 0);
    model_cnt = 0;
    step();
    rst_n = 1'b1;
    step();
    run_pattern(16'hC0DE, 16'hC0DE, 16'hC0DE, 1'b0, 1'b0, 1'b1);

    // pat_valid held high: back-to-back patterns, one IDLE cycle between them.
    pat_valid = 1'b1; pat_data = 16'hA5C3; pat_expect = 16'hA5C3;
    n_acc = 0; n_rv = 0; low = 0; changed = 1'b0;
    for (int k = 0; k < 200 && n_acc < 3; k++) begin
      if (n_acc > 0 && !shift_en) low++;
      if (resp_valid) begin
        if (n_rv < 2) begin rv_t[n_rv] = k; rv_r[n_rv] = resp; rv_f[n_rv] = fail; end
        n_rv++;
      end
      if (pat_valid && pat_ready) begin acc_t[n_acc] = k; n_acc++; end
      step();
      if (n_acc == 1 && !changed) begin
        pat_data = 16'h0F0F; pat_expect = 16'h0F0F; changed = 1'b1;
      end
    end
    pat_valid = 1'b0;
    check("b2b accepts", n_acc, 3);
    check("b2b period 1", acc_t[1] - acc_t[0], RV_LAT + 2);
    check("b2b period 2", acc_t[2] - acc_t[1], RV_LAT + 2);
    check("b2b one idle", acc_t[1] - rv_t[0], 1);
    check("b2b shift_en low", low, 2 * CC);
    check("b2b resp 1", rv_r[0], 16'hA5C3);
    check("b2b resp 2", rv_r[1], 16'h0F0F);
    check("b2b fail", {rv_f[0], rv_f[1]}, 2'b00);
    // Third pattern is in LOAD now; abort it there.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort in load", {shift_en, pat_ready}, 2'b11);
    check("final fail_cnt", fail_cnt, model_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_seq.md
SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16: scan chain length in bits; legal range 2..256.
REQ-002 SHALL have parameter CAPTURE_CYCLES, default 6: clk cycles with shift_en low per pattern; legal range 4..64.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port pat_valid, input, 1: pattern and expected response are offered.
REQ-006 SHALL have port pat_ready, output, 1: block accepts a pattern this cycle.
REQ-007 SHALL have port pat_data, input, CHAIN_LEN: stimulus to load into the chain.
REQ-008 SHALL have port pat_expect, input, CHAIN_LEN: expected captured response.
REQ-009 SHALL have port abort, input, 1: synchronous abandon of the current pattern.
REQ-010 SHALL have port clr_cnt, input, 1: synchronous clear of fail_cnt.
REQ-011 SHALL have port scan_in_o, output, 1: serial data to the chain head.
REQ-012 SHALL have port scan_out_i, input, 1: serial data from the chain tail.
REQ-013 SHALL have port shift_en, output, 1: 1 = shift mode, 0 = capture window for the downstream capture-pulse controller.
REQ-014 SHALL have port resp, output, CHAIN_LEN: unloaded response.
REQ-015 SHALL have port resp_valid, output, 1: one-cycle pulse, resp and fail valid.
REQ-016 SHALL have port fail, output, 1: resp differs from pat_expect.
REQ-017 SHALL have port fail_cnt, output, 8: saturating count of failing patterns.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD -> CAPTURE -> UNLOAD -> REPORT -> IDLE.
REQ-019 SHALL drive pat_ready=1 only in IDLE; accept on pat_valid && pat_ready; register pat_data and pat_expect; enter LOAD next cycle.
REQ-020 SHALL, in LOAD, hold shift_en=1 for exactly CHAIN_LEN cycles; scan_in_o = pat_data[k] in LOAD cycle k (LSB first).
REQ-021 SHALL, in CAPTURE, hold shift_en=0 for exactly CAPTURE_CYCLES cycles, scan_in_o=0.
REQ-022 SHALL, in UNLOAD, hold shift_en=1 for exactly CHAIN_LEN cycles; scan_out_i sampled at the end of UNLOAD cycle k is stored to resp[k]; scan_in_o=0.
REQ-023 SHALL, in REPORT (one cycle), assert resp_valid=1 and fail=(resp != registered expect); resp and fail SHALL hold until the next REPORT.
REQ-024 SHALL, in IDLE and REPORT, hold shift_en=1 so the downstream capture counter stays cleared.
REQ-025 SHALL increment fail_cnt in REPORT when fail=1, saturating at 255.
REQ-026 SHALL, on clr_cnt with a simultaneous failing REPORT, give fail_cnt=1 (clear, then count).
REQ-027 SHALL, on abort in LOAD, CAPTURE or UNLOAD, enter IDLE next cycle with shift_en=1; no resp_valid; fail_cnt is unchanged.
REQ-028 SHALL ignore abort in IDLE and REPORT.
REQ-029 SHALL ignore pat_valid outside IDLE.
REQ-030 SHALL allow back-to-back patterns: REPORT -> IDLE (one cycle) -> accept.
REQ-031 SHALL size phase counters to clog2(max(CHAIN_LEN, CAPTURE_CYCLES)) bits, with no wrap within a phase.

Reset
REQ-032 SHALL, on rst_n low, immediately reset state to IDLE: shift_en=1, pat_ready=0 until the first clock after release, scan_in_o=0, resp=0, resp_valid=0, fail=0, fail_cnt=0.
REQ-033 SHALL, on reset mid-pattern, discard the pattern with no resp_valid.

Structure
REQ-034 SHALL put the state enum and fail_cnt width constant in package scan_seq_pkg.
REQ-035 SHALL use one sub-module, scan_shreg: a CHAIN_LEN parallel-load/serial-shift register used for both load and unload.

Verification
REQ-036 SHALL check CHAIN_LEN=16, pat_data=16'hA5C3, scan_out_i looped from a 16-bit model chain, capture no-op, expect=16'hA5C3 -> resp=16'hA5C3, fail=0, resp_valid exactly 1 cycle after 16+6+16 cycles.
REQ-037 SHALL check the same stimulus with expect=16'hA5C2 -> fail=1, fail_cnt=1.
REQ-038 SHALL check abort in CAPTURE cycle 2 -> shift_en=1 next cycle, IDLE, no resp_valid, fail_cnt unchanged.
REQ-039 SHALL check 256 failing patterns -> fail_cnt saturates at 255; clr_cnt with a failing REPORT -> fail_cnt=1.
REQ-040 SHALL check rst_n low in UNLOAD cycle 5 -> all outputs at reset values asynchronously; next pattern completes normally.
REQ-041 SHALL check pat_valid held continuously -> consecutive patterns accepted with exactly one IDLE cycle between them; shift_en low for exactly 6 cycles per pattern.
